// File: rtl/alu_issue_queue.sv
// rtl/alu_issue_queue.sv - ALU reservation-station issue queue with CDB wakeup and result register
// Oldest-ready select by per-entry age; single dispatch and single issue per cycle.
module alu_issue_queue #(
    parameter int ROB_IX = 2,
    parameter int DEPTH  = 4
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              flush_in,
    input  logic              disp_valid_in,
    output logic              disp_ready_out,
    input  logic [3:0]        disp_func_in,
    input  logic [ROB_IX:0]   disp_rob_ix_in,
    input  logic              disp_rdy1_in,
    input  logic [ROB_IX:0]   disp_tag1_in,
    input  logic [31:0]       disp_val1_in,
    input  logic              disp_rdy2_in,
    input  logic [ROB_IX:0]   disp_tag2_in,
    input  logic [31:0]       disp_val2_in,
    input  logic              cdb_valid_in,
    input  logic [ROB_IX:0]   cdb_rob_ix_in,
    input  logic [31:0]       cdb_data_in,
    output logic              alu_valid_out,
    output logic [31:0]       alu_rval1_out,
    output logic [31:0]       alu_rval2_out,
    output logic [3:0]        alu_func_out,
    output logic [ROB_IX:0]   alu_rob_ix_out,
    input  logic [31:0]       alu_data_in,
    output logic              res_valid_out,
    output logic [ROB_IX:0]   res_rob_ix_out,
    output logic [31:0]       res_data_out,
    input  logic              res_read_in
);
    localparam int TW = ROB_IX + 1;
    localparam int AW = $clog2(DEPTH);

    typedef struct packed {
        logic          valid;
        logic [3:0]    func;
        logic [TW-1:0] rob_ix;
        logic          rdy1;
        logic [TW-1:0] tag1;
        logic [31:0]   val1;
        logic          rdy2;
        logic [TW-1:0] tag2;
        logic [31:0]   val2;
        logic [AW-1:0] age;
    } entry_t;

    entry_t        ent_q [DEPTH];
    entry_t        ent_d [DEPTH];
    logic          res_valid_q, res_valid_d;
    logic [TW-1:0] res_rob_ix_q, res_rob_ix_d;
    logic [31:0]   res_data_q, res_data_d;

    logic          any_elig, free_found, res_free, issue, dispatch;
    logic [AW-1:0] sel_ix, sel_age, free_ix;

    // Strict '>' keeps the lowest index on an (unexpected) age tie.
    always_comb begin
        any_elig   = 1'b0;
        sel_ix     = '0;
        sel_age    = '0;
        free_found = 1'b0;
        free_ix    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2 &&
                (!any_elig || ent_q[i].age > sel_age)) begin
                any_elig = 1'b1;
                sel_ix   = AW'(i);
                sel_age  = ent_q[i].age;
            end
            if (!ent_q[i].valid && !free_found) begin
                free_found = 1'b1;
                free_ix    = AW'(i);
            end
        end
    end

    assign res_free       = !res_valid_q || res_read_in;
    assign issue          = any_elig && res_free && !flush_in;
    assign dispatch       = disp_valid_in && free_found && !flush_in;
    assign disp_ready_out = free_found;

    assign alu_valid_out  = issue;
    assign alu_rval1_out  = issue ? ent_q[sel_ix].val1   : 32'd0;
    assign alu_rval2_out  = issue ? ent_q[sel_ix].val2   : 32'd0;
    assign alu_func_out   = issue ? ent_q[sel_ix].func   : 4'd0;
    assign alu_rob_ix_out = issue ? ent_q[sel_ix].rob_ix : '0;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ent_d[i] = ent_q[i];
            if (cdb_valid_in && ent_q[i].valid && !ent_q[i].rdy1 && ent_q[i].tag1 == cdb_rob_ix_in) begin
                ent_d[i].rdy1 = 1'b1;
                ent_d[i].val1 = cdb_data_in;
            end
            if (cdb_valid_in && ent_q[i].valid && !ent_q[i].rdy2 && ent_q[i].tag2 == cdb_rob_ix_in) begin
                ent_d[i].rdy2 = 1'b1;
                ent_d[i].val2 = cdb_data_in;
            end
            if (dispatch && ent_q[i].valid && ent_q[i].age != AW'(DEPTH - 1)) begin
                ent_d[i].age = ent_q[i].age + 1'b1;
            end
            if (issue && sel_ix == AW'(i)) begin
                ent_d[i].valid = 1'b0;
            end
            // A source still waiting at dispatch can be satisfied by this cycle's broadcast.
            if (dispatch && free_ix == AW'(i)) begin
                ent_d[i].valid  = 1'b1;
                ent_d[i].func   = disp_func_in;
                ent_d[i].rob_ix = disp_rob_ix_in;
                ent_d[i].age    = '0;
                ent_d[i].tag1   = disp_tag1_in;
                ent_d[i].tag2   = disp_tag2_in;
                ent_d[i].rdy1   = disp_rdy1_in;
                ent_d[i].val1   = disp_val1_in;
                ent_d[i].rdy2   = disp_rdy2_in;
                ent_d[i].val2   = disp_val2_in;
                if (!disp_rdy1_in && cdb_valid_in && disp_tag1_in == cdb_rob_ix_in) begin
                    ent_d[i].rdy1 = 1'b1;
                    ent_d[i].val1 = cdb_data_in;
                end
                if (!disp_rdy2_in && cdb_valid_in && disp_tag2_in == cdb_rob_ix_in) begin
                    ent_d[i].rdy2 = 1'b1;
                    ent_d[i].val2 = cdb_data_in;
                end
            end
            if (flush_in) begin
                ent_d[i].valid = 1'b0;
            end
        end
    end

    always_comb begin
        res_valid_d  = res_valid_q;
        res_rob_ix_d = res_rob_ix_q;
        res_data_d   = res_data_q;
        if (flush_in) begin
            res_valid_d = 1'b0;
        end else if (issue) begin
            res_valid_d  = 1'b1;
            res_rob_ix_d = alu_rob_ix_out;
            res_data_d   = alu_data_in;
        end else if (res_read_in) begin
            res_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
            res_valid_q  <= 1'b0;
            res_rob_ix_q <= '0;
            res_data_q   <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= ent_d[i];
            end
            res_valid_q  <= res_valid_d;
            res_rob_ix_q <= res_rob_ix_d;
            res_data_q   <= res_data_d;
        end
    end

    assign res_valid_out  = res_valid_q;
    assign res_rob_ix_out = res_rob_ix_q;
    assign res_data_out   = res_data_q;
endmodule

// File: doc/alu_issue_queue.md
ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

Interface
REQ-001 The block SHALL have parameter ROB_IX, default 2, meaning ROB index MSB (tag width ROB_IX+1).
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >=2).
REQ-003 The block SHALL have these ports: clk_in  in  1  clock; rst_in  in  1  reset, synchronous, active-high; flush_in  in  1  squash all in-flight work.
REQ-004 The block SHALL have these dispatch ports: disp_valid_in  in  1; disp_ready_out  out  1  not full; disp_func_in  in  4  AluFunc; disp_rob_ix_in  in  ROB_IX+1  destination tag.
REQ-005 The block SHALL have these source ports, for n=1,2: disp_rdyN_in  in  1  operand present; disp_tagN_in  in  ROB_IX+1  producer tag; disp_valN_in  in  32  operand value.
REQ-006 The block SHALL have these CDB snoop ports: cdb_valid_in  in  1; cdb_rob_ix_in  in  ROB_IX+1; cdb_data_in  in  32.
REQ-007 The block SHALL have these ALU drive ports: alu_valid_out  out  1; alu_rval1_out  out  32; alu_rval2_out  out  32; alu_func_out  out  4; alu_rob_ix_out  out  ROB_IX+1; alu_data_in  in  32  combinational ALU result.
REQ-008 The block SHALL have these result ports: res_valid_out  out  1; res_rob_ix_out  out  ROB_IX+1; res_data_out  out  32; res_read_in  in  1  CDB grant.

Function
REQ-009 Each entry SHALL hold: valid, func, rob_ix, rdy1/tag1/val1, rdy2/tag2/val2, and age (clog2(DEPTH) bits).
REQ-010 disp_ready_out SHALL be 1 iff at least one entry is invalid; an issue in the same cycle SHALL NOT count as freeing an entry.
REQ-011 When disp_valid_in && disp_ready_out && !flush_in, the lowest-index free entry SHALL be written at the next edge with age 0, and every other valid entry's age SHALL increment, saturating at DEPTH-1.
REQ-012 Dispatch with disp_valid_in=1 while disp_ready_out=0 SHALL be ignored with no state change.
REQ-013 When cdb_valid_in=1, every valid entry source with rdyN=0 and tagN==cdb_rob_ix_in SHALL capture cdb_data_in and set rdyN=1 at the next edge.
REQ-014 A dispatching source with disp_rdyN_in=0 whose tag matches a valid CDB broadcast in the same cycle SHALL be written with rdyN=1 and the CDB value (bypass).
REQ-015 An entry SHALL be issue-eligible when valid && rdy1 && rdy2; a wakeup captured this cycle SHALL make it eligible only from the next cycle.
REQ-016 The selected entry SHALL be the eligible entry with the greatest age; age ties SHALL NOT occur.
REQ-017 The result register SHALL be free when res_valid_out=0, or when res_valid_out=1 && res_read_in=1 in the same cycle.
REQ-018 alu_valid_out SHALL be asserted combinationally iff an eligible entry exists and the result register is free; alu_rval1/2_out, alu_func_out and alu_rob_ix_out SHALL carry the selected entry's fields, and SHALL be 0 when alu_valid_out=0.
REQ-019 On issue, the result register SHALL load alu_data_in and alu_rob_ix_out at the next edge, and the issued entry SHALL be invalidated at that edge.
REQ-020 res_valid_out SHALL hold, with stable data, until res_read_in=1; read with no new issue SHALL clear res_valid_out at the next edge.
REQ-021 Minimum latency SHALL be: dispatch with both operands ready in cycle N, alu_valid_out in N+1, res_valid_out in N+2.
REQ-022 At most one dispatch and one issue SHALL occur per cycle; simultaneous dispatch, issue and CDB wakeup SHALL all take effect at the same edge.
REQ-023 flush_in=1 SHALL clear all entry valids and res_valid_out at the next edge, overriding any dispatch, issue or wakeup that cycle; alu_valid_out SHALL be forced to 0 during flush_in.

Reset
REQ-024 rst_in=1 SHALL, at the next edge, clear all entry valids and ages and set res_valid_out=0, res_rob_ix_out=0 and res_data_out=0; disp_ready_out SHALL read 1 and alu_valid_out 0 from the first cycle after reset.
REQ-025 Reset mid-operation SHALL discard all entries and any pending result, with no residual issue afterward.

Verification
REQ-026 Directed test: dispatch Add, rob 3, val1=5, val2=7, both ready, res_read_in=1 -> alu_valid_out at N+1, res_valid_out=1, res_rob_ix_out=3, res_data_out=12 at N+2.
REQ-027 Directed test: dispatch Sub, rob 1, src1 ready=10, src2 waiting on tag 2; CDB tag 2 data 4 two cycles later -> issue the cycle after the CDB cycle, result 6.
REQ-028 Directed test: fill all 4 entries -> disp_ready_out=0, fifth dispatch ignored; after one issue, disp_ready_out=1 the following cycle.
REQ-029 Directed test: entries A (older) and B both become ready in the same cycle -> A issues first and B issues the next cycle; with res_read_in=0, B holds off and res_valid_out/data stay stable.
REQ-030 Directed test: dispatch with src2 tag 5 concurrent with CDB tag 5 data 9 -> entry ready immediately and issues next cycle with rval2=9.
REQ-031 Directed test: flush_in with 3 valid entries and res_valid_out=1 -> next cycle res_valid_out=0, disp_ready_out=1, and no alu_valid_out without a new dispatch.
